// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared definitions for the fabric-side AHB-Lite SRAM arbiter:
//   - arb_state_t    : transfer FSM states (IDLE, ADDR, DATA, RESP)
//   - HTRANS_*       : AHB-Lite transfer type encodings used by the master
//   - HRESP_*        : AHB-Lite slave response encodings
//   - HSIZE_*        : transfer size encodings (low two bits of HSIZE)
//   - is_legal()     : size/alignment check applied before any bus access
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    // A request is legal when its size is defined and its address is
    // naturally aligned to that size. Only the two low address bits matter.
    function automatic logic is_legal(input logic [1:0] size,
                                      input logic [1:0] addr_lsb);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lsb[0];
            HSIZE_WORD: ok = (addr_lsb == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// sram_arb_rr2
// Two-requester grant logic with a last_grant history register.
// Ports:
//   clk, resetn   : clock and synchronous active-low reset
//   req0, req1    : pending requests
//   enable        : high while the arbiter FSM is idle and may accept a grant
//   grant_valid   : at least one request is pending
//   grant_id      : winning requester (0 or 1), valid with grant_valid
// Parameter FIXED_PRIO=1 makes requester 0 always win; 0 selects round-robin.
module sram_arb_rr2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic req0,
    input  logic req1,
    input  logic enable,
    output logic grant_valid,
    output logic grant_id
);

    logic last_grant;

    // On a tie the requester that did not win last time is chosen, so a
    // losing requester is guaranteed the next slot.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (FIXED_PRIO != 0) begin
            grant_id = ~req0;
        end else if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end

    // History resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (enable && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/sram_ahb_arbiter.sv
// sram_ahb_arbiter
// AHB-Lite master sharing the external-SRAM CoreMemCtrl slave between two
// fabric requesters. One single transfer at a time, IDLE->ADDR->DATA->RESP.
// Ports:
//   CLK, RESETn               : FIC_0_CLK (also HCLK), synchronous active-low reset
//   reqN/weN/sizeN/addrN/wdataN : requester N transfer request and fields
//   ackN                      : one-cycle completion pulse to requester N
//   rdata, err                : read data and error status, valid with ackN
//   busy                      : FSM not idle
//   timeout                   : one-cycle pulse when a transfer is aborted
//   HSEL..HWDATA, HREADYIN    : AHB-Lite master outputs to the slave
//   HRDATA, HREADY, HRESP     : AHB-Lite slave responses
// Optional build macro SRAM_ARB_TIMEOUT_EN adds an abort counter limited by
// TIMEOUT_CYCLES; without it a transfer waits indefinitely and timeout is 0.
module sram_ahb_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FIXED_PRIO     = 0
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              timeout,
    output logic              HSEL,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [ADDR_W-1:0] HADDR,
    output logic [31:0]       HWDATA,
    output logic              HREADYIN,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sram_ahb_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    arb_state_t        state, state_n;
    logic              grant_valid, grant_id;
    logic              lat_id, lat_id_n, lat_we, lat_we_n;
    logic [1:0]        lat_size, lat_size_n;
    logic [ADDR_W-1:0] lat_addr, lat_addr_n;
    logic [31:0]       lat_wdata, lat_wdata_n;
    logic              sticky, sticky_n;
    logic              ack0_n, ack1_n, err_n, busy_n, hsel_n, hwrite_n;
    logic [31:0]       rdata_n, hwdata_n;
    logic [1:0]        htrans_n;
    logic [2:0]        hsize_n;
    logic [ADDR_W-1:0] haddr_n;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt, to_cnt_n;
    logic        timeout_n;
`endif

    assign HREADYIN = HREADY;

    assign sel_we    = grant_id ? we1    : we0;
    assign sel_size  = grant_id ? size1  : size0;
    assign sel_addr  = grant_id ? addr1  : addr0;
    assign sel_wdata = grant_id ? wdata1 : wdata0;

    sram_arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr2 (
        .clk         (CLK),
        .resetn      (RESETn),
        .req0        (req0),
        .req1        (req1),
        .enable      (state == ST_IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Next state plus next values of every registered output. Bus outputs
    // are decoded from the state being entered so that they appear on the
    // same edge that the FSM changes state.
    always_comb begin
        state_n     = state;
        lat_id_n    = lat_id;
        lat_we_n    = lat_we;
        lat_size_n  = lat_size;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        sticky_n    = sticky;
        rdata_n     = '0;
        err_n       = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
        to_cnt_n    = to_cnt;
        timeout_n   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    lat_id_n    = grant_id;
                    lat_we_n    = sel_we;
                    lat_size_n  = sel_size;
                    lat_addr_n  = sel_addr;
                    lat_wdata_n = sel_wdata;
                    sticky_n    = 1'b0;
                    if (is_legal(sel_size, sel_addr[1:0])) begin
                        state_n = ST_ADDR;
`ifdef SRAM_ARB_TIMEOUT_EN
                        to_cnt_n = '0;
`endif
                    end else begin
                        state_n = ST_RESP;
                        err_n   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HRESP == HRESP_ERROR) begin
                    sticky_n = 1'b1;
                end
                if (HREADY) begin
                    rdata_n = HRDATA;
                    err_n   = sticky | (HRESP == HRESP_ERROR);
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
`ifdef SRAM_ARB_TIMEOUT_EN
        // The abort wins over a slave completion arriving in the same cycle.
        if (state == ST_ADDR || state == ST_DATA) begin
            to_cnt_n = to_cnt + 16'd1;
            if (to_cnt == TO_LIMIT) begin
                state_n   = ST_RESP;
                err_n     = 1'b1;
                rdata_n   = '0;
                timeout_n = 1'b1;
            end
        end
`endif
        hsel_n   = 1'b0;
        htrans_n = HTRANS_IDLE;
        haddr_n  = '0;
        hwrite_n = 1'b0;
        hsize_n  = '0;
        hwdata_n = '0;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        case (state_n)
            ST_ADDR: begin
                hsel_n   = 1'b1;
                htrans_n = HTRANS_NONSEQ;
                haddr_n  = lat_addr_n;
                hwrite_n = lat_we_n;
                hsize_n  = {1'b0, lat_size_n};
            end
            ST_DATA: begin
                hwdata_n = lat_we_n ? lat_wdata_n : 32'h0;
            end
            ST_RESP: begin
                ack0_n = ~lat_id_n;
                ack1_n = lat_id_n;
            end
            default: begin
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State, latched request fields and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            sticky    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            HSEL      <= 1'b0;
            HWRITE    <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            HSIZE     <= '0;
            HADDR     <= '0;
            HWDATA    <= '0;
        end else begin
            state     <= state_n;
            lat_id    <= lat_id_n;
            lat_we    <= lat_we_n;
            lat_size  <= lat_size_n;
            lat_addr  <= lat_addr_n;
            lat_wdata <= lat_wdata_n;
            sticky    <= sticky_n;
            ack0      <= ack0_n;
            ack1      <= ack1_n;
            rdata     <= rdata_n;
            err       <= err_n;
            busy      <= busy_n;
            HSEL      <= hsel_n;
            HWRITE    <= hwrite_n;
            HTRANS    <= htrans_n;
            HSIZE     <= hsize_n;
            HADDR     <= haddr_n;
            HWDATA    <= hwdata_n;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Abort counter and its one-cycle timeout pulse.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            to_cnt  <= to_cnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
